// File: rtl/oclib_pkg.sv
// Shared LED controller types: per-LED mode encoding and the stored configuration record.
package oclib_pkg;

  localparam int LedLevelW = 12;
  localparam int LedRateW  = 4;

  typedef enum logic [2:0] {
    LedModeOff     = 3'd0,
    LedModeOn      = 3'd1,
    LedModeBlink   = 3'd2,
    LedModePwm     = 3'd3,
    LedModeBreathe = 3'd4,
    LedModeCount   = 3'd5
  } LedMode;

  // level is sized for the widest PWM; narrower builds zero-extend into it
  typedef struct packed {
    LedMode                mode;
    logic [LedLevelW-1:0]  level;
    logic [LedRateW-1:0]   rate;
  } LedCfg;

  // Reserved encodings (6, 7) fall back to OFF
  function automatic LedMode sanitize_mode(logic [2:0] raw);
    return (raw > 3'd5) ? LedModeOff : LedMode'(raw);
  endfunction

endpackage

// File: rtl/oc_led_channel.sv
// One LED: holds its configuration record and selects the drive waveform from the shared counters.
module oc_led_channel
  import oclib_pkg::*;
#(
  parameter int     SlowW      = 23,
  parameter int     PwmBits    = 8,
  parameter int     BlinkBase  = 10,
  parameter int     Index      = 0,
  parameter logic   ResetValue = 1'b0,
  parameter logic   Invert     = 1'b0,
  parameter LedMode ResetMode  = LedModeCount
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic [SlowW-1:0]   slow_count,
  input  logic [PwmBits-1:0] pwm_count,
  input  logic               wr_en,
  input  LedCfg              wr_cfg,
  output logic               led
);

  LedCfg                cfg;
  logic [SlowW-1:0]     slow_shift;
  logic [PwmBits-1:0]   tri_t;
  logic [PwmBits-1:0]   tri_eff;
  logic [LedLevelW-1:0] pwm_ext;
  logic                 raw;
  logic                 unused_slow;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cfg <= '{mode: ResetMode, level: '0, rate: '0};
    end else if (wr_en) begin
      cfg <= wr_cfg;
    end
  end

  // All slow-rate modes read the counter relative to bit BlinkBase+rate
  always_comb begin
    slow_shift = slow_count >> (BlinkBase + int'(cfg.rate));
    tri_t      = slow_shift[PwmBits-1:0];
    tri_eff    = slow_shift[PwmBits] ? ~tri_t : tri_t;
    pwm_ext    = '0;
    pwm_ext[PwmBits-1:0] = pwm_count;
    raw = 1'b0;
    case (cfg.mode)
      LedModeOff:     raw = 1'b0;
      LedModeOn:      raw = 1'b1;
      LedModeBlink:   raw = slow_shift[0];
      LedModePwm:     raw = (cfg.level > pwm_ext);
      LedModeBreathe: raw = (tri_eff > pwm_count);
      LedModeCount:   raw = slow_shift[Index];
      default:        raw = 1'b0;
    endcase
  end

  assign unused_slow = ^slow_shift;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      led <= ResetValue;
    end else begin
      led <= raw ^ Invert;
    end
  end

endmodule

// File: rtl/oc_led_ctrl.sv
// LED controller top: prescaler, global slow/PWM counters, single-beat config port and LED channels.
module oc_led_ctrl
  import oclib_pkg::*;
#(
  parameter int          LedCount     = 3,
  parameter int          PrescaleDiv  = 1000,
  parameter int          PwmBits      = 8,
  parameter int          BlinkBase    = 10,
  parameter logic [15:0] ResetPattern = 16'b101,
  parameter LedMode      ResetMode    = LedModeCount,
  parameter logic [15:0] LedInvert    = 16'b0
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                cfgValid,
  output logic                cfgReady,
  input  logic [3:0]          cfgLed,
  input  logic [2:0]          cfgMode,
  input  logic [PwmBits-1:0]  cfgLevel,
  input  logic [3:0]          cfgRate,
  output logic                cfgError,
  output logic [LedCount-1:0] ledOut
);

  localparam int SlowW = BlinkBase + 16 + PwmBits + LedCount;
  localparam int PreW  = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;

  logic [PreW-1:0]    pre_cnt;
  logic               tick;
  logic [SlowW-1:0]   slow_count;
  logic [PwmBits-1:0] pwm_count;
  logic               accept;
  logic               led_hit;
  logic               mode_bad;
  LedCfg              wr_cfg;

  assign tick = (pre_cnt == PreW'(PrescaleDiv - 1));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pre_cnt    <= '0;
      slow_count <= '0;
      pwm_count  <= '0;
    end else begin
      pre_cnt   <= tick ? '0 : pre_cnt + PreW'(1);
      pwm_count <= pwm_count + PwmBits'(1);
      if (tick) begin
        slow_count <= slow_count + SlowW'(1);
      end
    end
  end

  // Handshake: a write is taken when cfgValid && cfgReady on a clock edge;
  // cfgReady then drops for exactly the following cycle, so each accept is one beat.
  assign accept   = cfgValid && cfgReady;
  assign led_hit  = (int'(cfgLed) < LedCount);
  assign mode_bad = (cfgMode > 3'd5);

  always_comb begin
    wr_cfg       = '0;
    wr_cfg.mode  = sanitize_mode(cfgMode);
    wr_cfg.level[PwmBits-1:0] = cfgLevel;
    wr_cfg.rate  = cfgRate;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cfgReady <= 1'b0;
      cfgError <= 1'b0;
    end else begin
      cfgReady <= !accept;
      cfgError <= accept && (!led_hit || mode_bad);
    end
  end

  for (genvar g = 0; g < LedCount; g++) begin : g_led
    oc_led_channel #(
      .SlowW      (SlowW),
      .PwmBits    (PwmBits),
      .BlinkBase  (BlinkBase),
      .Index      (g),
      .ResetValue (ResetPattern[g] ^ LedInvert[g]),
      .Invert     (LedInvert[g]),
      .ResetMode  (ResetMode)
    ) u_channel (
      .clock      (clock),
      .resetN     (resetN),
      .slow_count (slow_count),
      .pwm_count  (pwm_count),
      .wr_en      (accept && led_hit && (cfgLed == 4'(g))),
      .wr_cfg     (wr_cfg),
      .led        (ledOut[g])
    );
  end

endmodule

// File: tb/tb_oc_led_ctrl.sv
// Directed bench for oc_led_ctrl with PrescaleDiv=4, BlinkBase=0, PwmBits=4, LedCount=3.
module tb_oc_led_ctrl;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       cfgValid = 1'b0;
  logic [3:0] cfgLed = '0;
  logic [2:0] cfgMode = '0;
  logic [3:0] cfgLevel = '0;
  logic [3:0] cfgRate = '0;
  logic       cfgReady, cfgReady_i;
  logic       cfgError, cfgError_i;
  logic [2:0] ledOut, ledOut_i;

  int errors = 0;
  int checks = 0;
  int cyc;
  int m_mode[3];
  int m_level[3];
  int m_rate[3];

  always #5 clock = ~clock;

  oc_led_ctrl #(.LedCount(3), .PrescaleDiv(4), .PwmBits(4), .BlinkBase(0)) dut (
    .clock(clock), .resetN(resetN), .cfgValid(cfgValid), .cfgReady(cfgReady),
    .cfgLed(cfgLed), .cfgMode(cfgMode), .cfgLevel(cfgLevel), .cfgRate(cfgRate),
    .cfgError(cfgError), .ledOut(ledOut)
  );

  oc_led_ctrl #(.LedCount(3), .PrescaleDiv(4), .PwmBits(4), .BlinkBase(0),
                .LedInvert(16'b001)) dut_inv (
    .clock(clock), .resetN(resetN), .cfgValid(cfgValid), .cfgReady(cfgReady_i),
    .cfgLed(cfgLed), .cfgMode(cfgMode), .cfgLevel(cfgLevel), .cfgRate(cfgRate),
    .cfgError(cfgError_i), .ledOut(ledOut_i)
  );

  // Edges since reset release; ledOut after edge n reflects counters held before edge n
  always @(posedge clock or negedge resetN) begin
    if (!resetN) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic logic exp_bit(int i, int n);
    int slow = (n - 1) / 4;
    int pwm  = (n - 1) % 16;
    int b    = m_rate[i];
    int t    = (slow >> b) & 15;
    int eff  = (((slow >> (b + 4)) & 1) != 0) ? 15 - t : t;
    case (m_mode[i])
      1:       return 1'b1;
      2:       return ((slow >> b) & 1) != 0;
      3:       return m_level[i] > pwm;
      4:       return eff > pwm;
      5:       return ((slow >> (b + i)) & 1) != 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_out(int n);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = exp_bit(i, n);
    return r;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 5; m_level[i] = 0; m_rate[i] = 0;
    end
  endtask

  // Driver: present one write at a negedge, return at the negedge after the accept edge
  task automatic write_cfg(input int led, input int mode, input int level, input int rate,
                           output logic rdy_acc, output logic rdy_after, output logic err_after,
                           output logic [2:0] led_old, output logic [2:0] exp_old);
    cfgLed = 4'(led); cfgMode = 3'(mode); cfgLevel = 4'(level); cfgRate = 4'(rate);
    cfgValid = 1'b1;
    rdy_acc = cfgReady;
    @(negedge clock);
    cfgValid = 1'b0;
    rdy_after = cfgReady;
    err_after = cfgError;
    led_old = ledOut;
    exp_old = exp_out(cyc);
    if (led < 3) begin
      m_mode[led] = (mode > 5) ? 0 : mode;
      m_level[led] = level;
      m_rate[led] = rate;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    resetN = 1'b0;
    reset_model();
    repeat (5) @(negedge clock);
    checks++;
    if (ledOut !== 3'b101) begin errors++; $display("FAIL reset_led: got %b expected 101", ledOut); end
    checks++;
    if (ledOut_i !== 3'b100) begin errors++; $display("FAIL reset_led_inv: got %b expected 100", ledOut_i); end
    checks++;
    if (cfgReady !== 1'b0 || cfgError !== 1'b0) begin
      errors++; $display("FAIL reset_hs: got ready=%b error=%b expected 0 0", cfgReady, cfgError);
    end
    resetN = 1'b1;
    @(negedge clock);
    checks++;
    if (cfgReady !== 1'b1) begin errors++; $display("FAIL ready_release: got %b expected 1", cfgReady); end
    for (int k = 0; k < 24; k++) begin
      if (ledOut !== exp_out(cyc) || ledOut_i !== (exp_out(cyc) ^ 3'b001)) begin
        if (bad == 0) $display("FAIL count_track: cyc %0d got %b/%b expected %b", cyc, ledOut, ledOut_i, exp_out(cyc));
        bad++;
      end
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL count_track_total: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_on_off();
    logic ra, rf, ef;
    logic [2:0] lo, eo;
    write_cfg(1, 1, 0, 0, ra, rf, ef, lo, eo);
    checks++;
    if (ra !== 1'b1 || rf !== 1'b0) begin errors++; $display("FAIL on_handshake: got ready %b then %b expected 1 then 0", ra, rf); end
    checks++;
    if (ef !== 1'b0) begin errors++; $display("FAIL on_error: got %b expected 0", ef); end
    checks++;
    if (lo !== eo) begin errors++; $display("FAIL on_not_early: got %b expected %b", lo, eo); end
    @(negedge clock);
    checks++;
    if (ledOut[1] !== 1'b1) begin errors++; $display("FAIL on_led1: got %b expected 1", ledOut[1]); end
    checks++;
    if (cfgReady !== 1'b1) begin errors++; $display("FAIL ready_back: got %b expected 1", cfgReady); end
    checks++;
    if (ledOut !== exp_out(cyc)) begin errors++; $display("FAIL on_all: got %b expected %b", ledOut, exp_out(cyc)); end
    write_cfg(0, 0, 0, 0, ra, rf, ef, lo, eo);
    @(negedge clock);
    checks++;
    if (ledOut[0] !== 1'b0 || ledOut[1] !== 1'b1) begin
      errors++; $display("FAIL off_led0: got %b expected x10", ledOut);
    end
  endtask

  task automatic pwm_frames(input int level);
    logic ra, rf, ef;
    logic [2:0] lo, eo;
    int bad = 0;
    write_cfg(2, 3, level, 0, ra, rf, ef, lo, eo);
    @(negedge clock);
    for (int f = 0; f < 4; f++) begin
      int cnt = 0;
      for (int k = 0; k < 16; k++) begin
        if (ledOut[2] === 1'b1) cnt++;
        if (ledOut !== exp_out(cyc)) bad++;
        @(negedge clock);
      end
      checks++;
      if (cnt != level) begin errors++; $display("FAIL pwm_frame L%0d F%0d: got %0d high expected %0d", level, f, cnt, level); end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pwm_phase L%0d: got %0d bad cycles expected 0", level, bad); end
  endtask

  task automatic test_pwm();
    pwm_frames(4);
    pwm_frames(0);
    pwm_frames(15);
  endtask

  task automatic test_blink();
    logic ra, rf, ef;
    logic [2:0] lo, eo;
    int bad = 0;
    int nchg = 0;
    int bad_iv = 0;
    int prev = -1;
    logic last;
    write_cfg(0, 2, 0, 2, ra, rf, ef, lo, eo);
    @(negedge clock);
    last = ledOut[0];
    for (int k = 0; k < 56; k++) begin
      if (ledOut[0] !== exp_bit(0, cyc) || ledOut_i[0] !== ~exp_bit(0, cyc)) bad++;
      if (ledOut[0] !== last) begin
        if (prev >= 0 && cyc - prev != 16) bad_iv++;
        prev = cyc;
        nchg++;
        last = ledOut[0];
      end
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL blink_wave: got %0d bad cycles expected 0", bad); end
    checks++;
    if (nchg < 3 || bad_iv != 0) begin
      errors++; $display("FAIL blink_period: got %0d toggles %0d bad gaps expected >=3 and 0", nchg, bad_iv);
    end
  endtask

  task automatic test_breathe();
    logic ra, rf, ef;
    logic [2:0] lo, eo;
    int bad = 0;
    write_cfg(2, 4, 0, 0, ra, rf, ef, lo, eo);
    @(negedge clock);
    for (int k = 0; k < 80; k++) begin
      if (ledOut !== exp_out(cyc)) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL breathe_wave: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_errors();
    logic ra, rf, ef;
    logic [2:0] lo, eo;
    write_cfg(3, 1, 9, 0, ra, rf, ef, lo, eo);
    checks++;
    if (ef !== 1'b1) begin errors++; $display("FAIL err_bad_led: got %b expected 1", ef); end
    @(negedge clock);
    checks++;
    if (cfgError !== 1'b0) begin errors++; $display("FAIL err_pulse_len: got %b expected 0", cfgError); end
    checks++;
    if (ledOut !== exp_out(cyc)) begin errors++; $display("FAIL err_no_change: got %b expected %b", ledOut, exp_out(cyc)); end
    write_cfg(1, 6, 5, 3, ra, rf, ef, lo, eo);
    checks++;
    if (ef !== 1'b1) begin errors++; $display("FAIL err_bad_mode: got %b expected 1", ef); end
    @(negedge clock);
    checks++;
    if (ledOut[1] !== 1'b0) begin errors++; $display("FAIL err_mode_off: got %b expected 0", ledOut[1]); end
    for (int k = 0; k < 4 && (cyc % 4) != 3; k++) @(negedge clock);
    write_cfg(0, 5, 0, 0, ra, rf, ef, lo, eo);
    checks++;
    if (ef !== 1'b0) begin errors++; $display("FAIL tick_write_err: got %b expected 0", ef); end
    @(negedge clock);
    checks++;
    if (ledOut[0] !== ((((cyc - 1) / 4) % 2) == 1)) begin
      errors++; $display("FAIL tick_write_led0: got %b expected %b", ledOut[0], (((cyc - 1) / 4) % 2) == 1);
    end
  endtask

  task automatic test_async_reset();
    logic ra, rf, ef;
    logic [2:0] lo, eo;
    int bad = 0;
    write_cfg(2, 3, 7, 0, ra, rf, ef, lo, eo);
    repeat (10) @(negedge clock);
    cfgLed = 4'd1; cfgMode = 3'd1; cfgLevel = 4'd0; cfgRate = 4'd0;
    cfgValid = 1'b1;
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if (ledOut !== 3'b101 || ledOut_i !== 3'b100) begin
      errors++; $display("FAIL async_reset_led: got %b/%b expected 101/100", ledOut, ledOut_i);
    end
    checks++;
    if (cfgReady !== 1'b0) begin errors++; $display("FAIL async_reset_ready: got %b expected 0", cfgReady); end
    cfgValid = 1'b0;
    reset_model();
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 32; k++) begin
      if (ledOut !== exp_out(cyc) || cfgError !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL async_release_count: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_on_off();
    test_pwm();
    test_blink();
    test_breathe();
    test_errors();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
